// File: rtl/x16_approx_div_pkg.sv
// Shared definitions for the x16 approximate divider family: widths, FSM encoding, divide-by-zero constant.
package x16_approx_div_pkg;

    localparam int DIV_W = 16;
    localparam int CNT_W = 4;

    localparam logic [DIV_W-1:0] DIV_BY_ZERO_Q = 16'hFFFF;
    localparam logic [CNT_W-1:0] CNT_MAX       = CNT_W'(DIV_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/x16_approx_div_sub.sv
// 17-bit trial subtractor: bits [N16-1:0] are borrow-less XOR, bits [16:N16] are an exact subtract whose
// borrow-out is the only borrow reported.
module x16_approx_sub
    import x16_approx_div_pkg::*;
#(
    parameter int N16 = 0
) (
    input  logic [DIV_W:0] a,
    input  logic [DIV_W:0] b,
    output logic [DIV_W:0] diff,
    output logic           borrow
);

    localparam int HW = DIV_W + 1 - N16;

    // One extra bit on top of the exact part captures its borrow-out.
    logic [HW:0] hi_ext;

    assign hi_ext = {1'b0, a[DIV_W:N16]} - {1'b0, b[DIV_W:N16]};
    assign borrow = hi_ext[HW];

    generate
        if (N16 > 0) begin : g_approx
            assign diff = {hi_ext[HW-1:0], a[N16-1:0] ^ b[N16-1:0]};
        end else begin : g_exact
            assign diff = hi_ext[HW-1:0];
        end
    endgenerate

endmodule

// File: rtl/x16_approx_div.sv
// Iterative 16-bit radix-2 restoring divider with an approximate low-bit trial subtract.
// Optional macro X16_APPROX_DIV_EARLY_EXIT_EN: dividend<divisor finishes in one cycle with quotient 0.
module x16_approx_div
    import x16_approx_div_pkg::*;
#(
    parameter int N16 = 0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] part_q, part_d;   // partial remainder R
    logic [DIV_W-1:0] qacc_q, qacc_d;   // quotient bits shifted in MSB first
    logic [DIV_W-1:0] dvd_q, dvd_d;
    logic [DIV_W-1:0] dvs_q, dvs_d;
    logic [DIV_W-1:0] quo_q, quo_d;
    logic [DIV_W-1:0] rem_q, rem_d;

    logic [DIV_W:0]   trial_s;
    logic [DIV_W:0]   trial_d;
    logic             trial_borrow;
    logic             trial_d_msb_unused;
    logic [DIV_W-1:0] calc_part;
    logic [DIV_W-1:0] calc_qacc;

    assign trial_s = {part_q, dvd_q[cnt_q]};

    x16_approx_sub #(.N16(N16)) u_sub (
        .a      (trial_s),
        .b      ({1'b0, dvs_q}),
        .diff   (trial_d),
        .borrow (trial_borrow)
    );

    assign trial_d_msb_unused = trial_d[DIV_W];
    assign calc_part = trial_borrow ? trial_s[DIV_W-1:0] : trial_d[DIV_W-1:0];
    assign calc_qacc = {qacc_q[DIV_W-2:0], ~trial_borrow};

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;

    // NOTE: every next-state signal gets its hold value first, so no path through the case leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        qacc_d  = qacc_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    dvd_d = dividend;
                    dvs_d = divisor;
                    if (divisor == '0) begin
                        quo_d   = DIV_BY_ZERO_Q;
                        rem_d   = dividend;
                        state_d = ST_DONE;
`ifdef X16_APPROX_DIV_EARLY_EXIT_EN
                    end else if (dividend < divisor) begin
                        quo_d   = '0;
                        rem_d   = dividend;
                        state_d = ST_DONE;
`endif
                    end else begin
                        part_d  = '0;
                        qacc_d  = '0;
                        cnt_d   = CNT_MAX;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                part_d = calc_part;
                qacc_d = calc_qacc;
                if (cnt_q == '0) begin
                    quo_d   = calc_qacc;
                    rem_d   = calc_part;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples the pre-edge values;
    // the reset is asynchronous and aborts any division in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            part_q  <= '0;
            qacc_q  <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            qacc_q  <= qacc_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_x16_approx_div.sv
// Scoreboard bench: an exact divider (N16=0) and an approximate one (N16=4) share the same stimulus.
module tb_x16_approx_div;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        out_ready = 1'b1;

    logic        in_ready0, out_valid0, in_ready4, out_valid4;
    logic [15:0] quotient0, remainder0, quotient4, remainder4;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit rand_ready = 1'b0;
    bit seen_first = 1'b0;

    typedef struct {
        logic [15:0] q0, r0, q4, r4;
        int          lat;
        int          acc;
    } exp_t;
    exp_t exp_q[$];

    x16_approx_div #(.N16(0)) dut0 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready0),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid0), .out_ready(out_ready),
        .quotient(quotient0), .remainder(remainder0)
    );

    x16_approx_div #(.N16(4)) dut4 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready4),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid4), .out_ready(out_ready),
        .quotient(quotient4), .remainder(remainder4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Long division one bit at a time; the low n bits of each trial subtract are XOR with no borrow.
    function automatic void ref_approx(input int n, input logic [15:0] a, input logic [15:0] b,
                                       output logic [15:0] q, output logic [15:0] r);
        int rr, s, hi;
        q = '0;
        rr = 0;
        if (b == 0) begin
            q = 16'hFFFF;
            r = a;
            return;
        end
`ifdef X16_APPROX_DIV_EARLY_EXIT_EN
        if (a < b) begin
            r = a;
            return;
        end
`endif
        for (int i = 15; i >= 0; i--) begin
            s  = rr * 2 + ((int'(a) >> i) & 1);
            hi = (s >> n) - (int'(b) >> n);
            if (hi >= 0) begin
                q[i] = 1'b1;
                rr = ((hi << n) | ((s ^ int'(b)) & ((1 << n) - 1))) & 16'hFFFF;
            end else begin
                rr = s & 16'hFFFF;
            end
        end
        r = rr[15:0];
    endfunction

    function automatic int ref_latency(input logic [15:0] a, input logic [15:0] b);
        if (b == 0) return 1;
`ifdef X16_APPROX_DIV_EARLY_EXIT_EN
        if (a < b) return 1;
`endif
        return 17;
    endfunction

    function automatic exp_t make_exp(input logic [15:0] a, input logic [15:0] b, input int acc);
        exp_t e;
        if (b == 0) begin
            e.q0 = 16'hFFFF;
            e.r0 = a;
        end else begin
            e.q0 = a / b;
            e.r0 = a % b;
        end
        ref_approx(4, a, b, e.q4, e.r4);
        e.lat = ref_latency(a, b);
        e.acc = acc;
        return e;
    endfunction

    // Present operands and hold them until accepted; the accept cycle is the one whose negedge sees in_ready.
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        int budget = 0;
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        forever begin
            @(negedge clk);
            if (in_ready0) break;
            budget++;
            if (budget > 200) begin
                check("accept_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back(make_exp(a, b, cyc));
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
    endtask

    task automatic wait_drain(input int limit);
        int budget = 0;
        while (exp_q.size() != 0 && budget < limit) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (resetn && out_valid0) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", {31'd0, out_valid0}, 32'd0);
            end else begin
                if (!seen_first) begin
                    check("latency", cyc - exp_q[0].acc, exp_q[0].lat);
                    seen_first = 1'b1;
                end
                check("valid4", {31'd0, out_valid4}, 32'd1);
                check("in_ready_done", {31'd0, in_ready0}, 32'd0);
                check("quot_exact", quotient0, exp_q[0].q0);
                check("rem_exact", remainder0, exp_q[0].r0);
                check("quot_n4", quotient4, exp_q[0].q4);
                check("rem_n4", remainder4, exp_q[0].r4);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    seen_first = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        logic [15:0] a, b;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready0}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid0}, 32'd0);
        check("rst_quotient", quotient0, 32'd0);
        check("rst_remainder", remainder0, 32'd0);
        #1 resetn = 1'b1;

        // Directed cases from the test plan.
        issue(16'd1000, 16'd7);
        wait_drain(100);
        issue(16'h1234, 16'd0);
        wait_drain(100);
        issue(16'd5, 16'd9);
        wait_drain(100);

        // Consumer stalls for five cycles with a result pending.
        out_ready = 1'b0;
        issue(16'd65535, 16'd1);
        budget = 0;
        while (!out_valid0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("stall_valid_seen", {31'd0, out_valid0}, 32'd1);
        repeat (5) @(posedge clk);
        #2 out_ready = 1'b1;
        wait_drain(100);

        // Asynchronous reset in the middle of a division.
        issue(16'd1000, 16'd7);
        wait_drain(100);
        issue(16'd100, 16'd3);
        repeat (6) @(posedge clk);
        #3;
        check("pre_reset_quotient", quotient0, 32'd142);
        resetn = 1'b0;
        #1;
        check("async_out_valid", {31'd0, out_valid0}, 32'd0);
        check("async_quotient", quotient0, 32'd0);
        check("async_remainder", remainder0, 32'd0);
        exp_q.delete();
        seen_first = 1'b0;
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", {31'd0, in_ready0}, 32'd1);
        issue(16'd100, 16'd10);
        wait_drain(100);

        // Random operands with a bias toward zero, small divisors and dividend < divisor.
        rand_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 16'd0;
                1:       b = 16'($urandom_range(1, 15));
                2:       b = a + 16'($urandom_range(1, 50));
                default: b = 16'($urandom);
            endcase
            issue(a, b);
        end
        wait_drain(500);
        rand_ready = 1'b0;
        out_ready  = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
